// File: rtl/dual_edge_decoder.sv
// Rebuilds a signal's level from a stream of per-edge pulses and measures each
// phase in clock cycles, flagging pulse spacing the encoder can never produce.
`timescale 1ns/1ps
module dual_edge_decoder #(
  parameter int unsigned CNT_W      = 16,
  parameter bit          INIT_LEVEL = 1'b0,
  parameter int unsigned MIN_GAP    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             edge_pulse,
  input  logic             clear,
  output logic             level,
  output logic [CNT_W-1:0] width,
  output logic             width_is_high,
  output logic             width_valid,
  output logic             gap_err
);

  localparam logic [2:0] IDLE_LOW   = 3'b001;
  localparam logic [2:0] IDLE_HIGH  = 3'b010;
  localparam logic [2:0] FAULT      = 3'b100;
  localparam logic [2:0] INIT_STATE = INIT_LEVEL ? IDLE_HIGH : IDLE_LOW;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GAP_MIN = CNT_W'(MIN_GAP);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             first, first_nxt;
  logic             level_nxt;
  logic [CNT_W-1:0] width_nxt;
  logic             width_is_high_nxt;
  logic             width_valid_nxt;
  logic             gap_err_nxt;

  // Saturating increment doubles as the spacing of a pulse arriving this cycle.
  logic [CNT_W-1:0] cnt_inc_c;
  logic             gap_ok_c;

  assign cnt_inc_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign gap_ok_c  = (cnt_inc_c >= GAP_MIN);

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= INIT_STATE;
      level         <= INIT_LEVEL;
      cnt           <= CNT_MAX;
      first         <= 1'b1;
      width         <= '0;
      width_is_high <= 1'b0;
      width_valid   <= 1'b0;
      gap_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      level         <= level_nxt;
      cnt           <= cnt_nxt;
      first         <= first_nxt;
      width         <= width_nxt;
      width_is_high <= width_is_high_nxt;
      width_valid   <= width_valid_nxt;
      gap_err       <= gap_err_nxt;
    end
  end

  // Next-state and next-output logic; clear overrides any pulse this cycle
  always_comb begin
    state_nxt         = state;
    level_nxt         = level;
    cnt_nxt           = cnt_inc_c;
    first_nxt         = first;
    width_nxt         = width;
    width_is_high_nxt = width_is_high;
    width_valid_nxt   = 1'b0;
    gap_err_nxt       = gap_err;

    if (clear) begin
      state_nxt         = INIT_STATE;
      level_nxt         = INIT_LEVEL;
      cnt_nxt           = CNT_MAX;
      first_nxt         = 1'b1;
      width_is_high_nxt = 1'b0;
      gap_err_nxt       = 1'b0;
    end else begin
      case (state)
        IDLE_LOW, IDLE_HIGH: begin
          if (edge_pulse) begin
            if (gap_ok_c) begin
              state_nxt = (state == IDLE_LOW) ? IDLE_HIGH : IDLE_LOW;
              level_nxt = (state == IDLE_LOW);
              cnt_nxt   = '0;
              first_nxt = 1'b0;
              // The phase before the first pulse has no known start.
              if (!first) begin
                width_nxt         = cnt_inc_c;
                width_is_high_nxt = level;
                width_valid_nxt   = 1'b1;
              end
            end else begin
              state_nxt   = FAULT;
              gap_err_nxt = 1'b1;
            end
          end
        end
        FAULT: begin
          cnt_nxt = cnt;
        end
        default: begin
          state_nxt = INIT_STATE;
          level_nxt = INIT_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_edge_decoder.sv
// Self-checking bench for dual_edge_decoder: default, CNT_W=4 and INIT_LEVEL=1
// instances sharing one clock and reset, with a scoreboard for width reports.
`timescale 1ns/1ps
module tb_dual_edge_decoder;

  logic clk;
  logic reset_n;

  logic        pulse0, clr0, level0, wih0, wv0, gap0;
  logic [15:0] width0;
  logic        pulse4, clr4, level4, wih4, wv4, gap4;
  logic [3:0]  width4;
  logic        pulse6, clr6, level6, wih6, wv6, gap6;
  logic [15:0] width6;

  dual_edge_decoder u0 (
    .clk(clk), .reset_n(reset_n), .edge_pulse(pulse0), .clear(clr0),
    .level(level0), .width(width0), .width_is_high(wih0),
    .width_valid(wv0), .gap_err(gap0)
  );

  dual_edge_decoder #(.CNT_W(4)) u4 (
    .clk(clk), .reset_n(reset_n), .edge_pulse(pulse4), .clear(clr4),
    .level(level4), .width(width4), .width_is_high(wih4),
    .width_valid(wv4), .gap_err(gap4)
  );

  dual_edge_decoder #(.INIT_LEVEL(1'b1)) u6 (
    .clk(clk), .reset_n(reset_n), .edge_pulse(pulse6), .clear(clr6),
    .level(level6), .width(width6), .width_is_high(wih6),
    .width_valid(wv6), .gap_err(gap6)
  );

  typedef struct {
    int cyc;
    int w;
    bit hi;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    pulse0 = 0; clr0 = 0; pulse4 = 0; clr4 = 0; pulse6 = 0; clr6 = 0;
    reset_n = 0;
    repeat (3) tick();
    reset_n = 1;
    cyc = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    pulse0 = 0; clr0 = 0; pulse4 = 0; clr4 = 0; pulse6 = 0; clr6 = 0;
    reset_n = 0;
    #1;
    total++;
    if (level0 !== 1'b0 || wv0 !== 1'b0 || gap0 !== 1'b0 || width0 !== 16'd0 || wih0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got lvl=%b v=%b g=%b w=%0d hi=%b exp 0 0 0 0 0", level0, wv0, gap0, width0, wih0);
    end
    repeat (3) tick();
    reset_n = 1;
    cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      total++;
      if (level0 !== 1'b0 || wv0 !== 1'b0 || gap0 !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got lvl=%b v=%b g=%b exp 0 0 0", c, level0, wv0, gap0);
      end
      total++;
      if (level6 !== 1'b1 || wv6 !== 1'b0) begin
        bad++;
        $display("FAIL reset_init_high cyc=%0d got lvl=%b v=%b exp 1 0", c, level6, wv6);
      end
    end
  endtask

  task automatic test_pulses();
    logic exp_lvl;
    exp_t e;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        total++;
        if (wv0 !== 1'b1 || width0 !== 16'(e.w) || wih0 !== e.hi) begin
          bad++;
          $display("FAIL pulses_width cyc=%0d got v=%b w=%0d hi=%b exp v=1 w=%0d hi=%b", c, wv0, width0, wih0, e.w, e.hi);
        end
      end else begin
        total++;
        if (wv0 !== 1'b0) begin
          bad++;
          $display("FAIL pulses_novalid cyc=%0d got v=%b exp 0", c, wv0);
        end
      end
      exp_lvl = (c >= 11 && c < 16) || c >= 23;
      total++;
      if (level0 !== exp_lvl || gap0 !== 1'b0) begin
        bad++;
        $display("FAIL pulses_level cyc=%0d got lvl=%b g=%b exp lvl=%b g=0", c, level0, gap0, exp_lvl);
      end
      pulse0 = (c == 10 || c == 15 || c == 22);
      if (c == 15) sb.push_back('{16, 5, 1'b1});
      if (c == 22) sb.push_back('{23, 7, 1'b0});
    end
    pulse0 = 0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pulses_drain got pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_gap_fault();
    logic exp_lvl, exp_gap;
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      tick();
      exp_lvl = (c >= 11 && c < 21);
      exp_gap = (c >= 12 && c < 21);
      total++;
      if (level0 !== exp_lvl || gap0 !== exp_gap || wv0 !== 1'b0) begin
        bad++;
        $display("FAIL gap_fault cyc=%0d got lvl=%b g=%b v=%b exp lvl=%b g=%b v=0", c, level0, gap0, wv0, exp_lvl, exp_gap);
      end
      pulse0 = (c == 10 || c == 11 || c == 14);
      clr0   = (c == 20);
    end
    pulse0 = 0;
    clr0   = 0;
  endtask

  task automatic test_saturate();
    logic exp_lvl;
    exp_t e;
    do_reset();
    for (int c = 1; c <= 115; c++) begin
      tick();
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        total++;
        if (wv4 !== 1'b1 || width4 !== 4'(e.w) || wih4 !== e.hi) begin
          bad++;
          $display("FAIL sat_width cyc=%0d got v=%b w=%0d hi=%b exp v=1 w=%0d hi=%b", c, wv4, width4, wih4, e.w, e.hi);
        end
      end else if (wv4 !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL sat_novalid cyc=%0d got v=%b exp 0", c, wv4);
      end
      exp_lvl = (c >= 11 && c < 111);
      if (c == 11 || c == 110 || c == 111 || c == 115) begin
        total++;
        if (level4 !== exp_lvl || gap4 !== 1'b0) begin
          bad++;
          $display("FAIL sat_level cyc=%0d got lvl=%b g=%b exp lvl=%b g=0", c, level4, gap4, exp_lvl);
        end
      end
      pulse4 = (c == 10 || c == 110);
      if (c == 110) sb.push_back('{111, 15, 1'b1});
    end
    pulse4 = 0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sat_drain got pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic exp_lvl;
    exp_t e;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      tick();
      total++;
      if (level0 !== (c >= 11) || wv0 !== 1'b0) begin
        bad++;
        $display("FAIL mid_pre cyc=%0d got lvl=%b v=%b exp lvl=%b v=0", c, level0, wv0, (c >= 11));
      end
      pulse0 = (c == 10);
    end
    pulse0 = 0;
    #4;
    reset_n = 0;
    #1;
    total++;
    if (level0 !== 1'b0 || width0 !== 16'd0 || wv0 !== 1'b0 || gap0 !== 1'b0) begin
      bad++;
      $display("FAIL mid_async got lvl=%b w=%0d v=%b g=%b exp 0 0 0 0", level0, width0, wv0, gap0);
    end
    repeat (2) tick();
    reset_n = 1;
    cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        total++;
        if (wv0 !== 1'b1 || width0 !== 16'(e.w) || wih0 !== e.hi) begin
          bad++;
          $display("FAIL mid_width cyc=%0d got v=%b w=%0d hi=%b exp v=1 w=%0d hi=%b", c, wv0, width0, wih0, e.w, e.hi);
        end
      end else begin
        total++;
        if (wv0 !== 1'b0) begin
          bad++;
          $display("FAIL mid_novalid cyc=%0d got v=%b exp 0", c, wv0);
        end
      end
      exp_lvl = (c >= 6 && c < 10);
      total++;
      if (level0 !== exp_lvl) begin
        bad++;
        $display("FAIL mid_level cyc=%0d got lvl=%b exp %b", c, level0, exp_lvl);
      end
      pulse0 = (c == 5 || c == 9);
      if (c == 9) sb.push_back('{10, 4, 1'b1});
    end
    pulse0 = 0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL mid_drain got pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_clear_pulse();
    logic exp_lvl;
    exp_t e;
    do_reset();
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        total++;
        if (wv6 !== 1'b1 || width6 !== 16'(e.w) || wih6 !== e.hi) begin
          bad++;
          $display("FAIL clr_width cyc=%0d got v=%b w=%0d hi=%b exp v=1 w=%0d hi=%b", c, wv6, width6, wih6, e.w, e.hi);
        end
      end else begin
        total++;
        if (wv6 !== 1'b0) begin
          bad++;
          $display("FAIL clr_novalid cyc=%0d got v=%b exp 0", c, wv6);
        end
      end
      exp_lvl = (c < 16) || (c >= 19);
      total++;
      if (level6 !== exp_lvl || gap6 !== 1'b0) begin
        bad++;
        $display("FAIL clr_level cyc=%0d got lvl=%b g=%b exp lvl=%b g=0", c, level6, gap6, exp_lvl);
      end
      clr6   = (c == 12);
      pulse6 = (c == 12 || c == 15 || c == 18);
      if (c == 18) sb.push_back('{19, 3, 1'b0});
    end
    clr6   = 0;
    pulse6 = 0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL clr_drain got pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic exp_lvl;
    exp_t e;
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        total++;
        if (wv0 !== 1'b1 || width0 !== 16'(e.w) || wih0 !== e.hi) begin
          bad++;
          $display("FAIL b2b_width cyc=%0d got v=%b w=%0d hi=%b exp v=1 w=%0d hi=%b", c, wv0, width0, wih0, e.w, e.hi);
        end
      end else begin
        total++;
        if (wv0 !== 1'b0) begin
          bad++;
          $display("FAIL b2b_novalid cyc=%0d got v=%b exp 0", c, wv0);
        end
      end
      exp_lvl = (c >= 11 && c < 13) || c >= 15;
      total++;
      if (level0 !== exp_lvl || gap0 !== 1'b0) begin
        bad++;
        $display("FAIL b2b_level cyc=%0d got lvl=%b g=%b exp lvl=%b g=0", c, level0, gap0, exp_lvl);
      end
      pulse0 = (c == 10 || c == 12 || c == 14);
      if (c == 12) sb.push_back('{13, 2, 1'b1});
      if (c == 14) sb.push_back('{15, 2, 1'b0});
    end
    pulse0 = 0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain got pending=%0d exp 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_pulses();
    test_gap_fault();
    test_saturate();
    test_reset_mid();
    test_clear_pulse();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
